// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: ALU operation codes, the zero word and
// the per-requester request bundle.
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } alu_op_t;

    localparam logic [31:0] ZERO = 32'h0000_0000;

    typedef struct packed {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
    } arb_req_t;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational requester picker for the ALU arbiter.
//   valid_i : request vector
//   ptr_i   : last granted index (round-robin mode only)
//   en_i    : grant enable; all-zero grant when low
//   gnt_o   : one-hot grant or zero
//   idx_o   : encoded index of the granted requester (0 when no grant)
// RR_EN=1 searches ptr_i+1, ptr_i+2, ... modulo NUM_REQ; RR_EN=0 is fixed
// priority with the lowest index winning.
module alu_arb_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = $clog2(NUM_REQ),
    parameter bit          RR_EN   = 1'b0
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);

    logic              found;
    int unsigned       cand;
    logic [ID_W-1:0]   cand_idx;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (RR_EN) begin
                cand = (32'(ptr_i) + k + 1) % NUM_REQ;
            end else begin
                cand = k;
            end
            cand_idx = ID_W'(cand);
            if (en_i && !found && valid_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters. One request issues per
// cycle; its operands drive the ALU combinationally and the ALU result returns
// to the issuing requester one cycle later as a single-cycle strobe.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration (adds the
// last-grant pointer flop); otherwise fixed priority, lowest index wins.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                kill the response due this cycle and block issue
//   req_valid_i/ready_o    per-requester handshake, ready is one-hot or zero
//   req_op_i/a_i/b_i       per-requester operation and operands
//   rsp_valid_o            per-requester result strobe
//   rsp_result_o/zero_o    shared result bus and zero flag
//   alu_op_o/a_o/b_o       ALU drive
//   alu_result_i/zero_i    registered ALU result and zero flag
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ-1:0][3:0]  req_op_i,
    input  logic [NUM_REQ-1:0][31:0] req_a_i,
    input  logic [NUM_REQ-1:0][31:0] req_b_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    output logic [31:0]              rsp_result_o,
    output logic                     rsp_zero_o,
    output logic [3:0]               alu_op_o,
    output logic [31:0]              alu_a_o,
    output logic [31:0]              alu_b_o,
    input  logic [31:0]              alu_result_i,
    input  logic                     alu_zero_i
);

`ifdef ALU_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    last_q;
    logic               grant_en;
    logic               issue;
    logic               inflight_v_q;
    logic [ID_W-1:0]    inflight_id_q;
    logic               rsp_fire;
    arb_req_t           sel;

    // Reset is part of the grant gate so nothing is accepted while it is held.
    assign grant_en = rst_ni && !flush_i;

    alu_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .RR_EN   (RR_EN)
    ) u_pick (
        .valid_i (req_valid_i),
        .ptr_i   (last_q),
        .en_i    (grant_en),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx)
    );

    assign req_ready_o = gnt;
    assign issue       = |gnt;

    always_comb begin
        sel.op = ALU_NONE;
        sel.a  = ZERO;
        sel.b  = ZERO;
        if (issue) begin
            sel.op = alu_op_t'(req_op_i[gnt_idx]);
            sel.a  = req_a_i[gnt_idx];
            sel.b  = req_b_i[gnt_idx];
        end
    end

    assign alu_op_o = sel.op;
    assign alu_a_o  = sel.a;
    assign alu_b_o  = sel.b;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_v_q  <= 1'b0;
            inflight_id_q <= '0;
        end else begin
            inflight_v_q  <= issue;
            inflight_id_q <= gnt_idx;
        end
    end

`ifdef ALU_ARB_RR_EN
    // Resets to the top index so requester 0 is searched first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= ID_W'(NUM_REQ - 1);
        end else if (issue) begin
            last_q <= gnt_idx;
        end
    end
`else
    assign last_q = ID_W'(NUM_REQ - 1);
`endif

    assign rsp_fire = inflight_v_q && !flush_i;

    always_comb begin
        rsp_valid_o  = '0;
        rsp_result_o = ZERO;
        rsp_zero_o   = 1'b0;
        if (rsp_fire) begin
            rsp_valid_o[inflight_id_q] = 1'b1;
            rsp_result_o               = alu_result_i;
            rsp_zero_o                 = alu_zero_i;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with three requesters and a registered ALU model.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int unsigned NUM_REQ = 3;

    logic                     clk_i;
    logic                     rst_ni;
    logic                     flush_i;
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ-1:0][3:0]  req_op_i;
    logic [NUM_REQ-1:0][31:0] req_a_i;
    logic [NUM_REQ-1:0][31:0] req_b_i;
    logic [NUM_REQ-1:0]       rsp_valid_o;
    logic [31:0]              rsp_result_o;
    logic                     rsp_zero_o;
    logic [3:0]               alu_op_o;
    logic [31:0]              alu_a_o;
    logic [31:0]              alu_b_o;
    logic [31:0]              alu_result_i;
    logic                     alu_zero_i;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_result_o (rsp_result_o),
        .rsp_zero_o   (rsp_zero_o),
        .alu_op_o     (alu_op_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_result_i (alu_result_i),
        .alu_zero_i   (alu_zero_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Registered ALU: result appears one cycle after the operands.
    logic [31:0] alu_next;
    always_comb begin
        alu_next = 32'h0;
        case (alu_op_t'(alu_op_o))
            ALU_ADD: alu_next = alu_a_o + alu_b_o;
            ALU_SUB: alu_next = alu_a_o - alu_b_o;
            ALU_AND: alu_next = alu_a_o & alu_b_o;
            ALU_OR:  alu_next = alu_a_o | alu_b_o;
            ALU_XOR: alu_next = alu_a_o ^ alu_b_o;
            default: alu_next = 32'h0;
        endcase
    end

    always @(posedge clk_i) begin
        alu_result_i <= alu_next;
        alu_zero_i   <= (alu_next == 32'h0);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int idx, input alu_op_t op, input logic [31:0] a,
                           input logic [31:0] b);
        req_op_i[idx] = op;
        req_a_i[idx]  = a;
        req_b_i[idx]  = b;
    endtask

    // Hand-computed results of the round-robin stimulus per granted requester.
    function automatic logic [31:0] rr_result(input logic [2:0] g);
        case (g)
            3'b001:  return 32'd3;
            3'b010:  return 32'd12;
            3'b100:  return 32'h33;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    logic [2:0] exp_gnt [6];

    initial begin
`ifdef ALU_ARB_RR_EN
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        exp_gnt = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
        alu_result_i = 32'h0;
        alu_zero_i   = 1'b0;
        flush_i      = 1'b0;
        rst_ni       = 1'b0;
        req_valid_i  = 3'b111;
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        set_req(1, ALU_ADD, 32'd5, 32'd7);
        set_req(2, ALU_OR, 32'h30, 32'h03);

        // Reset with all requesters valid
        #3;
        check_eq("rst_ready", req_ready_o, 3'b000);
        check_eq("rst_alu_op", alu_op_o, ALU_NONE);
        check_eq("rst_alu_a", alu_a_o, 32'h0);
        check_eq("rst_alu_b", alu_b_o, 32'h0);
        check_eq("rst_rsp_valid", rsp_valid_o, 3'b000);
        check_eq("rst_rsp_result", rsp_result_o, 32'h0);
        check_eq("rst_rsp_zero", rsp_zero_o, 1'b0);
        step();
        rst_ni = 1'b1;

        // Arbitration with all requesters held valid
        for (int c = 0; c < 6; c++) begin
            #1;
            check_eq($sformatf("arb_gnt%0d", c), req_ready_o, exp_gnt[c]);
            check_eq($sformatf("arb_result_bus%0d", c), alu_next, rr_result(exp_gnt[c]));
            if (c > 0) begin
                check_eq($sformatf("arb_rsp_v%0d", c), rsp_valid_o, exp_gnt[c-1]);
                check_eq($sformatf("arb_rsp_r%0d", c), rsp_result_o, rr_result(exp_gnt[c-1]));
            end else begin
                check_eq("arb_rsp_v0", rsp_valid_o, 3'b000);
            end
            step();
        end
        req_valid_i = 3'b000;
        #1;
        check_eq("arb_drain_v", rsp_valid_o, exp_gnt[5]);
        check_eq("arb_drain_r", rsp_result_o, rr_result(exp_gnt[5]));
        check_eq("arb_drain_ready", req_ready_o, 3'b000);
        step();

        // Single op: requester 1 ADD 5+7
        req_valid_i = 3'b010;
        set_req(1, ALU_ADD, 32'd5, 32'd7);
        #1;
        check_eq("single_ready", req_ready_o, 3'b010);
        check_eq("single_op", alu_op_o, ALU_ADD);
        check_eq("single_a", alu_a_o, 32'd5);
        check_eq("single_b", alu_b_o, 32'd7);
        step();
        req_valid_i = 3'b000;
        #1;
        check_eq("single_rsp_v", rsp_valid_o, 3'b010);
        check_eq("single_rsp_r", rsp_result_o, 32'd12);
        check_eq("single_rsp_z", rsp_zero_o, 1'b0);
        check_eq("single_idle_op", alu_op_o, ALU_NONE);
        step();

        // Back-to-back with zero flag
        req_valid_i = 3'b001;
        set_req(0, ALU_SUB, 32'd9, 32'd9);
        #1;
        check_eq("b2b_ready0", req_ready_o, 3'b001);
        step();
        set_req(0, ALU_XOR, 32'hF0, 32'h0F);
        #1;
        check_eq("b2b_ready1", req_ready_o, 3'b001);
        check_eq("b2b_rsp_v1", rsp_valid_o, 3'b001);
        check_eq("b2b_rsp_r1", rsp_result_o, 32'h0);
        check_eq("b2b_rsp_z1", rsp_zero_o, 1'b1);
        step();
        req_valid_i = 3'b000;
        #1;
        check_eq("b2b_rsp_v2", rsp_valid_o, 3'b001);
        check_eq("b2b_rsp_r2", rsp_result_o, 32'hFF);
        check_eq("b2b_rsp_z2", rsp_zero_o, 1'b0);
        step();

        // Flush kills the due response and blocks issue
        req_valid_i = 3'b100;
        set_req(2, ALU_AND, 32'hFF, 32'h0F);
        #1;
        check_eq("flush_issue", req_ready_o, 3'b100);
        step();
        flush_i = 1'b1;
        #1;
        check_eq("flush_rsp_v", rsp_valid_o, 3'b000);
        check_eq("flush_rsp_r", rsp_result_o, 32'h0);
        check_eq("flush_ready", req_ready_o, 3'b000);
        check_eq("flush_alu_op", alu_op_o, ALU_NONE);
        step();
        flush_i     = 1'b0;
        req_valid_i = 3'b000;
        #1;
        check_eq("flush_after_v", rsp_valid_o, 3'b000);
        step();

        // Async reset mid-operation
        req_valid_i = 3'b010;
        set_req(1, ALU_ADD, 32'd5, 32'd7);
        #1;
        check_eq("areset_issue", req_ready_o, 3'b010);
        step();
        req_valid_i = 3'b000;
        #1;
        check_eq("areset_pre_v", rsp_valid_o, 3'b010);
        rst_ni = 1'b0;
        #1;
        check_eq("areset_rsp_v", rsp_valid_o, 3'b000);
        check_eq("areset_rsp_r", rsp_result_o, 32'h0);
        #1;
        rst_ni      = 1'b1;
        req_valid_i = 3'b111;
        #1;
        check_eq("areset_ptr", req_ready_o, 3'b001);
        check_eq("areset_after_v", rsp_valid_o, 3'b000);
        step();
        req_valid_i = 3'b000;
        #1;
        check_eq("areset_next_v", rsp_valid_o, 3'b001);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single registered ALU between up to four execute-stage requesters (e.g. integer execute, branch compare, address generation). It selects one request per cycle, drives the ALU operands and operation code, and returns the result to the issuing requester one cycle later. Issue is fully pipelined, so one operation can issue every cycle, and a flush input drops in-flight work.

## Interface
- NUM_REQ, 2: number of requesters, legal 2..4
- ID_W, $clog2(NUM_REQ): width of the internal requester tag
- clk_i  in  1  clock; all flops on rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  drop in-flight op, block issue this cycle
- req_valid_i  in  NUM_REQ  request pending, one bit per requester
- req_ready_o  out  NUM_REQ  grant, one-hot or zero
- req_op_i  in  NUM_REQ x 4  ALU operation code per requester
- req_a_i  in  NUM_REQ x 32  operand A per requester
- req_b_i  in  NUM_REQ x 32  operand B per requester
- rsp_valid_o  out  NUM_REQ  one-cycle result strobe, at most one bit set
- rsp_result_o  out  32  shared result bus
- rsp_zero_o  out  1  result equals zero
- alu_op_o  out  4  ALU operation
- alu_a_o  out  32  ALU operand A
- alu_b_o  out  32  ALU operand B
- alu_result_i  in  32  ALU registered result
- alu_zero_i  in  1  ALU zero flag

## Operation
- Issue: a request from requester i issues in cycle T when req_valid_i[i] && req_ready_o[i]. req_ready_o is combinational from req_valid_i, the priority pointer, flush_i and rst_ni. Requesters must not make valid depend on ready. A valid request must be held stable until it is granted.
- Grant is suppressed (req_ready_o all zero) while rst_ni is low or flush_i is high.
- ALU drive: on issue, alu_op_o, alu_a_o and alu_b_o are the granted requester's fields, passed through combinationally. With no issue, alu_op_o is ALU_NONE and both operands are 0.
- Tag register: on each rising edge, inflight_v <= issue and inflight_id <= granted index.
- Response: in cycle T+1, rsp_valid_o[inflight_id] = inflight_v && !flush_i.
  - rsp_result_o = alu_result_i and rsp_zero_o = alu_zero_i when any rsp_valid_o bit is set.
  - Otherwise rsp_result_o = 0 and rsp_zero_o = 0.
- No response backpressure. A requester must sink its strobe in the cycle it is asserted.
- Arbitration (round-robin, see Configuration):
  - Pointer last_q holds the last granted index.
  - Search order is last_q+1, last_q+2, … modulo NUM_REQ. The first valid requester wins.
  - last_q updates only on issue. Wrap from NUM_REQ-1 to 0.
- Simultaneous events:
  - Issue and response in the same cycle are normal; this is back-to-back operation.
  - flush_i in cycle T kills the response due in T and also blocks issue in T, so nothing is in flight at T+1.
- Reset mid-operation: an asynchronous assertion clears inflight_v immediately. Any pending result is lost with no strobe.

## Timing
- Reset values:
  - req_ready_o = 0 and rsp_valid_o = 0.
  - rsp_result_o = 0 and rsp_zero_o = 0.
  - alu_op_o = ALU_NONE, alu_a_o = 0, alu_b_o = 0.
  - inflight_v = 0 and last_q = NUM_REQ-1, so requester 0 wins first.
- Latency: exactly 1 cycle from issue edge to response strobe.
- Throughput: 1 op/cycle sustained.
- Fairness: with all requesters continuously valid, each is granted once every NUM_REQ cycles.
- Combinational paths: req_valid_i to req_ready_o to alu_* within one cycle; alu_result_i to rsp_result_o.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration as above, with the last_q pointer present.
- ALU_ARB_RR_EN undefined: fixed priority, lowest index wins, and there is no last_q flop.
- All other behaviour is identical in both builds.

## Structure
- Shared constants package: alu_op_t (4-bit enum including ALU_NONE), the ZERO constant, and arb_req_t (op, a, b struct).
- One sub-module, alu_arb_pick: a purely combinational arbiter.
  - Inputs: valid vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - It is parameterised by NUM_REQ and the RR/fixed mode.
- The tag register, ALU drive mux and response gating live in alu_arbiter.

## Test plan
- **Reset:** hold rst_ni=0 with all req_valid_i=1 → req_ready_o=0, alu_op_o=ALU_NONE, rsp_valid_o=0. After release, requester 0 is granted first.
- **Single op:** req 1 issues ADD with a=5, b=7 at T → alu_op_o=ADD at T; rsp_valid_o=2'b10, rsp_result_o=12, rsp_zero_o=0 at T+1.
- **Round-robin (RR build, NUM_REQ=3):** all valid for 6 cycles → grant order 0,1,2,0,1,2, with responses following one cycle behind. Repeat in the fixed-priority build → grant 0 every cycle.
- **Back-to-back zero flag:** req 0 SUB with 9−9 at T, then XOR with 0xF0^0x0F at T+1 → at T+1 result 0 and zero=1; at T+2 result 0xFF and zero=0.
- **Flush:** issue at T with flush_i=1 at T+1 → no strobe at T+1, req_ready_o=0 at T+1, nothing in flight at T+2.
- **Async reset mid-op:** issue at T, then pulse rst_ni low mid-cycle before T+1 → no strobe, and last_q returns to NUM_REQ-1.
